// File: rtl/nios_led_sequencer_if.sv
// -----------------------------------------------------------------------------
// nios_led_sequencer_if
//
// Bundles both Avalon-MM sides of the LED sequencer:
//   s_*  register slave, driven by the interconnect / CPU.
//   m_*  master write port that drives the LED PIO's s1 port.
//
// Modports:
//   slave  - view taken by the sequencer itself (receives s_* requests,
//            returns s_readdata and drives the m_* PIO write port).
//   master - opposite view, used by whatever sits around the sequencer
//            (interconnect model, testbench).
// -----------------------------------------------------------------------------
interface nios_led_sequencer_if;
    logic [1:0]  s_address;
    logic        s_chipselect;
    logic        s_write_n;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;

    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;

    modport slave (
        input  s_address,
        input  s_chipselect,
        input  s_write_n,
        input  s_writedata,
        output s_readdata,
        output m_address,
        output m_chipselect,
        output m_write_n,
        output m_writedata
    );

    modport master (
        output s_address,
        output s_chipselect,
        output s_write_n,
        output s_writedata,
        input  s_readdata,
        input  m_address,
        input  m_chipselect,
        input  m_write_n,
        input  m_writedata
    );
endinterface

// File: rtl/nios_led_sequencer.sv
// -----------------------------------------------------------------------------
// nios_led_sequencer
//
// Autonomous blink-pattern controller for a 1-bit LED PIO. The CPU programs
// CONTROL / PERIOD / PATTERN through the register slave; the block then writes
// the PIO one pattern bit per step period, LSB first, and finishes with a
// write of 0 (OFF) either at the end of a one-shot run or on abort.
//
// Ports:
//   clk      single system clock
//   reset_n  synchronous, active-low reset
//   bus      nios_led_sequencer_if.slave
//              s_address/s_chipselect/s_write_n/s_writedata/s_readdata :
//                register slave, zero wait states, combinational read
//              m_address/m_chipselect/m_write_n/m_writedata :
//                PIO write master, one-cycle pulse per LED update
//
// Register map:
//   0 CONTROL  bit0 enable, bit1 loop
//   1 PERIOD   step length in cycles (0 behaves as 1)
//   2 PATTERN  [PATTERN_W-1:0], step 0 = bit0
//   3 STATUS   bit0 busy, [8 +: IDX_W] step, bit16 done; any write clears done
// -----------------------------------------------------------------------------
module nios_led_sequencer #(
    parameter int PATTERN_W = 8,
    parameter int PERIOD_W  = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    nios_led_sequencer_if.slave bus
);

    localparam int IDX_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
    localparam logic [IDX_W-1:0] LAST_STEP = IDX_W'(PATTERN_W - 1);

    // ADVANCE is not a state: it is folded into the WRITE/WAIT exit logic.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WAIT,
        ST_OFF
    } state_t;

    state_t                state_reg, state_next;
    logic [IDX_W-1:0]      step_reg, step_next;
    logic [PERIOD_W-1:0]   count_reg, count_next;
    // Set when OFF is reached through the end of a one-shot run (as opposed
    // to an abort), so OFF knows whether to clear enable and raise done.
    logic                  oneshot_reg, oneshot_next;

    logic                  enable_reg;
    logic                  loop_reg;
    logic                  done_reg;
    logic [PERIOD_W-1:0]   period_reg;
    logic [PATTERN_W-1:0]  pattern_reg;

    logic                  cpu_wr;
    logic                  advance;
    logic                  off_oneshot;
    logic                  pulse;
    logic                  led_bit;
    logic                  busy;
    logic [PERIOD_W-1:0]   period_m1;
    logic [31:0]           rdata;

    assign cpu_wr      = bus.s_chipselect && !bus.s_write_n;
    assign busy        = (state_reg != ST_IDLE);
    assign off_oneshot = (state_reg == ST_OFF) && oneshot_reg;

    // Wait length after a WRITE: max(PERIOD,1)-1 cycles.
    assign period_m1 = (period_reg == '0) ? '0 : period_reg - PERIOD_W'(1);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        step_next    = step_reg;
        count_next   = count_reg;
        oneshot_next = oneshot_reg;
        advance      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (enable_reg) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                count_next = period_m1;
                if (!enable_reg) begin
                    // Abort wins over any advance decision this cycle.
                    state_next   = ST_OFF;
                    oneshot_next = 1'b0;
                end else if (period_m1 != '0) begin
                    state_next = ST_WAIT;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_WAIT: begin
                count_next = count_reg - PERIOD_W'(1);
                if (!enable_reg) begin
                    state_next   = ST_OFF;
                    oneshot_next = 1'b0;
                end else if (count_reg == PERIOD_W'(1)) begin
                    advance = 1'b1;
                end
            end
            ST_OFF: begin
                state_next   = ST_IDLE;
                step_next    = '0;
                oneshot_next = 1'b0;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (advance) begin
            if (step_reg < LAST_STEP) begin
                step_next  = step_reg + IDX_W'(1);
                state_next = ST_WRITE;
            end else if (loop_reg) begin
                step_next  = '0;
                state_next = ST_WRITE;
            end else begin
                state_next   = ST_OFF;
                oneshot_next = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State and register file
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            step_reg    <= '0;
            count_reg   <= '0;
            oneshot_reg <= 1'b0;
            enable_reg  <= 1'b0;
            loop_reg    <= 1'b0;
            done_reg    <= 1'b0;
            period_reg  <= '0;
            pattern_reg <= '0;
        end else begin
            state_reg   <= state_next;
            step_reg    <= step_next;
            count_reg   <= count_next;
            oneshot_reg <= oneshot_next;

            // The end of a one-shot run drops enable; a CPU CONTROL write in
            // the same cycle is applied afterwards and therefore wins.
            if (off_oneshot) begin
                enable_reg <= 1'b0;
            end

            if (cpu_wr) begin
                case (bus.s_address)
                    2'd0: begin
                        enable_reg <= bus.s_writedata[0];
                        loop_reg   <= bus.s_writedata[1];
                    end
                    2'd1: period_reg  <= bus.s_writedata[PERIOD_W-1:0];
                    2'd2: pattern_reg <= bus.s_writedata[PATTERN_W-1:0];
                    default: done_reg <= 1'b0;
                endcase
            end

            // Completion is an event; it is not lost to a coincident clear.
            if (off_oneshot) begin
                done_reg <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Register read mux (combinational, zero wait states)
    // -------------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        case (bus.s_address)
            2'd0: begin
                rdata[0] = enable_reg;
                rdata[1] = loop_reg;
            end
            2'd1: rdata[PERIOD_W-1:0]  = period_reg;
            2'd2: rdata[PATTERN_W-1:0] = pattern_reg;
            default: begin
                rdata[0]          = busy;
                rdata[8 +: IDX_W] = step_reg;
                rdata[16]         = done_reg;
            end
        endcase
    end

    assign bus.s_readdata = rdata;

    // -------------------------------------------------------------------------
    // PIO write master: WRITE sends the current pattern bit, OFF sends 0.
    // -------------------------------------------------------------------------
    assign pulse   = (state_reg == ST_WRITE) || (state_reg == ST_OFF);
    assign led_bit = (state_reg == ST_WRITE) && pattern_reg[step_reg];

    assign bus.m_address    = 2'b00;
    assign bus.m_chipselect = pulse;
    assign bus.m_write_n    = !pulse;
    assign bus.m_writedata  = {31'b0, led_bit};

endmodule

// File: tb/tb_nios_led_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nios_led_sequencer
//
// Directed bench for nios_led_sequencer (PATTERN_W = 8, PERIOD_W = 32).
// A negedge monitor logs every PIO write pulse (cycle number and data); each
// scenario task programs the registers, lets the sequence run and compares
// the log and register reads against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_nios_led_sequencer;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    nios_led_sequencer_if bus ();

    nios_led_sequencer #(
        .PATTERN_W (8),
        .PERIOD_W  (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    int          cyc = 0;
    int          pulse_cyc[$];
    logic [31:0] pulse_dat[$];
    int          wn_low   = 0;
    int          adr_bad  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.m_chipselect === 1'b1) begin
            pulse_cyc.push_back(cyc);
            pulse_dat.push_back(bus.m_writedata);
            if (bus.m_address !== 2'b00) adr_bad <= adr_bad + 1;
        end
        if (bus.m_write_n === 1'b0) wn_low <= wn_low + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required bench completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- helpers
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d, output int landed);
        bus.s_address    = a;
        bus.s_writedata  = d;
        bus.s_chipselect = 1'b1;
        bus.s_write_n    = 1'b0;
        @(posedge clk);
        #1;
        landed           = cyc;
        bus.s_chipselect = 1'b0;
        bus.s_write_n    = 1'b1;
        $display("[TB] cycle %0d write reg %0d = 0x%08h", landed, a, d);
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        bus.s_address = a;
        #1;
        d = bus.s_readdata;
        $display("[TB] cycle %0d read reg %0d = 0x%08h", cyc, a, d);
    endtask

    task automatic clear_log();
        pulse_cyc.delete();
        pulse_dat.delete();
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        int          t;
        logic [31:0] r;
        cpu_write(2'd1, 32'd5, t);
        cpu_write(2'd2, 32'hFF, t);
        clear_log();
        cpu_write(2'd0, 32'h1, t);
        step(12);
        tests_run++;
        if (pulse_cyc.size() < 2) begin
            tests_failed++;
            $display("FAIL reset_prerun_pulses: got %0d pulses, required at least 2", pulse_cyc.size());
        end
        reset_n = 1'b0;
        step(3);
        reset_n = 1'b1;
        clear_log();
        for (int a = 0; a < 4; a++) begin
            cpu_read(a[1:0], r);
            tests_run++;
            if (r !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_reg%0d: got 0x%08h, required 0x00000000", a, r);
            end
        end
        tests_run++;
        if (bus.m_write_n !== 1'b1 || bus.m_chipselect !== 1'b0 || bus.m_writedata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_master: got write_n=%b cs=%b data=0x%08h, required 1 0 0",
                     bus.m_write_n, bus.m_chipselect, bus.m_writedata);
        end
        step(20);
        tests_run++;
        if (pulse_cyc.size() !== 0) begin
            tests_failed++;
            $display("FAIL reset_no_pulse: got %0d pulses, required 0", pulse_cyc.size());
        end
    endtask

    task automatic test_one_shot();
        int          t0;
        int          n0;
        logic [31:0] r;
        logic [8:0]  exp_bits;
        exp_bits = 9'b0_1011_0101;
        cpu_write(2'd2, 32'hB5, t0);
        cpu_write(2'd1, 32'd4, t0);
        clear_log();
        n0 = wn_low;
        cpu_write(2'd0, 32'h1, t0);
        step(45);
        tests_run++;
        if (pulse_cyc.size() !== 9) begin
            tests_failed++;
            $display("FAIL oneshot_count: got %0d pulses, required 9", pulse_cyc.size());
        end
        for (int k = 0; k < 9; k++) begin
            tests_run++;
            if (k >= pulse_cyc.size()) begin
                tests_failed++;
                $display("FAIL oneshot_pulse%0d: got no pulse, required cycle %0d", k, t0 + 1 + 4 * k);
            end else if (pulse_cyc[k] !== t0 + 1 + 4 * k || pulse_dat[k] !== {31'b0, exp_bits[k]}) begin
                tests_failed++;
                $display("FAIL oneshot_pulse%0d: got cycle %0d data %0h, required cycle %0d data %0h",
                         k, pulse_cyc[k], pulse_dat[k], t0 + 1 + 4 * k, exp_bits[k]);
            end
        end
        tests_run++;
        if (wn_low - n0 !== 9) begin
            tests_failed++;
            $display("FAIL oneshot_write_n: got %0d low cycles, required 9", wn_low - n0);
        end
        cpu_read(2'd3, r);
        tests_run++;
        if (r !== 32'h0001_0000) begin
            tests_failed++;
            $display("FAIL oneshot_status: got 0x%08h, required 0x00010000", r);
        end
        cpu_read(2'd0, r);
        tests_run++;
        if (r !== 32'h0) begin
            tests_failed++;
            $display("FAIL oneshot_control: got 0x%08h, required 0x00000000", r);
        end
    endtask

    task automatic test_done_clear();
        int          t0;
        logic [31:0] r;
        cpu_write(2'd3, 32'hFFFF_FFFF, t0);
        cpu_read(2'd3, r);
        tests_run++;
        if (r !== 32'h0) begin
            tests_failed++;
            $display("FAIL done_clear_status: got 0x%08h, required 0x00000000", r);
        end
        cpu_write(2'd2, 32'h01, t0);
        cpu_write(2'd1, 32'd2, t0);
        clear_log();
        cpu_write(2'd0, 32'h1, t0);
        step(25);
        tests_run++;
        if (pulse_cyc.size() !== 9) begin
            tests_failed++;
            $display("FAIL restart_count: got %0d pulses, required 9", pulse_cyc.size());
        end
        tests_run++;
        if (pulse_cyc.size() < 2) begin
            tests_failed++;
            $display("FAIL restart_first: got %0d pulses, required at least 2", pulse_cyc.size());
        end else if (pulse_cyc[0] !== t0 + 1 || pulse_dat[0] !== 32'h1 ||
                     pulse_cyc[1] !== t0 + 3 || pulse_dat[1] !== 32'h0) begin
            tests_failed++;
            $display("FAIL restart_first: got cycles %0d,%0d data %0h,%0h, required %0d,%0d data 1,0",
                     pulse_cyc[0], pulse_cyc[1], pulse_dat[0], pulse_dat[1], t0 + 1, t0 + 3);
        end
        cpu_read(2'd3, r);
        tests_run++;
        if (r !== 32'h0001_0000) begin
            tests_failed++;
            $display("FAIL restart_status: got 0x%08h, required 0x00010000", r);
        end
        cpu_write(2'd3, 32'h0, t0);
    endtask

    task automatic test_loop_period0();
        int          t0;
        logic [31:0] r;
        logic [31:0] exp_d;
        cpu_write(2'd2, 32'h01, t0);
        cpu_write(2'd1, 32'd0, t0);
        clear_log();
        cpu_write(2'd0, 32'h3, t0);
        step(30);
        cpu_read(2'd3, r);
        tests_run++;
        if (r[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL loop_busy: got %b, required 1", r[0]);
        end
        cpu_read(2'd0, r);
        tests_run++;
        if (r !== 32'h3) begin
            tests_failed++;
            $display("FAIL loop_control: got 0x%08h, required 0x00000003", r);
        end
        for (int k = 0; k < 24; k++) begin
            exp_d = (k % 8 == 0) ? 32'h1 : 32'h0;
            tests_run++;
            if (k >= pulse_cyc.size()) begin
                tests_failed++;
                $display("FAIL loop_pulse%0d: got no pulse, required cycle %0d", k, t0 + 1 + k);
            end else if (pulse_cyc[k] !== t0 + 1 + k || pulse_dat[k] !== exp_d) begin
                tests_failed++;
                $display("FAIL loop_pulse%0d: got cycle %0d data %0h, required cycle %0d data %0h",
                         k, pulse_cyc[k], pulse_dat[k], t0 + 1 + k, exp_d);
            end
        end
        cpu_write(2'd0, 32'h0, t0);
        step(4);
        cpu_read(2'd3, r);
        tests_run++;
        if (r !== 32'h0) begin
            tests_failed++;
            $display("FAIL loop_stop_status: got 0x%08h, required 0x00000000", r);
        end
    endtask

    task automatic test_abort();
        int          t0;
        int          ta;
        logic [31:0] r;
        cpu_write(2'd2, 32'hFF, t0);
        cpu_write(2'd1, 32'd10, t0);
        cpu_write(2'd0, 32'h3, t0);
        step(14);
        clear_log();
        cpu_write(2'd0, 32'h0, ta);
        step(1);
        cpu_read(2'd3, r);
        tests_run++;
        if (r[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_busy_off: got %b, required 1", r[0]);
        end
        step(1);
        cpu_read(2'd3, r);
        tests_run++;
        if (r !== 32'h0) begin
            tests_failed++;
            $display("FAIL abort_status: got 0x%08h, required 0x00000000", r);
        end
        step(12);
        tests_run++;
        if (pulse_cyc.size() !== 1) begin
            tests_failed++;
            $display("FAIL abort_count: got %0d pulses, required 1", pulse_cyc.size());
        end else if (pulse_cyc[0] !== ta + 1 || pulse_dat[0] !== 32'h0) begin
            tests_failed++;
            $display("FAIL abort_off: got cycle %0d data %0h, required cycle %0d data 0",
                     pulse_cyc[0], pulse_dat[0], ta + 1);
        end
        tests_run++;
        if (adr_bad !== 0) begin
            tests_failed++;
            $display("FAIL pio_address: got %0d nonzero-address pulses, required 0", adr_bad);
        end
    endtask

    task automatic test_live_update();
        int          t0;
        int          t;
        int          exp_off [9];
        logic [8:0]  exp_bits;
        exp_off  = '{1, 4, 7, 10, 16, 22, 28, 34, 40};
        exp_bits = 9'b0_1111_0111;
        cpu_write(2'd2, 32'h0F, t0);
        cpu_write(2'd1, 32'd3, t0);
        clear_log();
        cpu_write(2'd0, 32'h3, t0);
        step(7);
        cpu_write(2'd1, 32'd6, t);
        cpu_write(2'd2, 32'hF0, t);
        step(33);
        for (int k = 0; k < 9; k++) begin
            tests_run++;
            if (k >= pulse_cyc.size()) begin
                tests_failed++;
                $display("FAIL live_pulse%0d: got no pulse, required cycle %0d", k, t0 + exp_off[k]);
            end else if (pulse_cyc[k] !== t0 + exp_off[k] || pulse_dat[k] !== {31'b0, exp_bits[k]}) begin
                tests_failed++;
                $display("FAIL live_pulse%0d: got cycle %0d data %0h, required cycle %0d data %0h",
                         k, pulse_cyc[k], pulse_dat[k], t0 + exp_off[k], exp_bits[k]);
            end
        end
        cpu_write(2'd0, 32'h0, t);
        step(4);
    endtask

    // ------------------------------------------------------------------- main
    initial begin
        bus.s_address    = 2'd0;
        bus.s_chipselect = 1'b0;
        bus.s_write_n    = 1'b1;
        bus.s_writedata  = 32'h0;
        reset_n          = 1'b0;
        step(3);
        reset_n = 1'b1;
        step(1);

        test_reset();
        test_one_shot();
        test_done_clear();
        test_loop_period0();
        test_abort();
        test_live_update();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
